// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package uc_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_IN_WAIT = 3'd5,
    S_OUT     = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  localparam logic [5:0]
    OP_RTYPE = 6'd0,  OP_SHIFT = 6'd1,  OP_JR   = 6'd2,  OP_ANDI = 6'd3,
    OP_ORI   = 6'd4,  OP_ADDI  = 6'd5,  OP_SUBI = 6'd6,  OP_LI   = 6'd7,
    OP_LW1   = 6'd8,  OP_LW2   = 6'd9,  OP_LW3  = 6'd10, OP_SW   = 6'd11,
    OP_BEQ   = 6'd12, OP_BLT   = 6'd13, OP_BGT  = 6'd14, OP_BNE  = 6'd15,
    OP_IN    = 6'd16, OP_OUT   = 6'd17, OP_MOVE = 6'd18, OP_J    = 6'd19,
    OP_JAL   = 6'd20, OP_HALT  = 6'd21, OP_NOP  = 6'd22;

  localparam logic [3:0]
    ALU_LDST = 4'b0000, ALU_RTYPE = 4'b0001, ALU_BEQ  = 4'b0010,
    ALU_BLT  = 4'b0011, ALU_BGT   = 4'b0100, ALU_BNE  = 4'b0101,
    ALU_ANDI = 4'b0110, ALU_ORI   = 4'b0111, ALU_ADDI = 4'b1000,
    ALU_SUBI = 4'b1001;

  localparam logic [1:0] RD_RT    = 2'b00, RD_RD    = 2'b01, RD_RA   = 2'b10;
  localparam logic [1:0] M2R_MEM  = 2'b00, M2R_ALU  = 2'b01, M2R_PC  = 2'b10;
  localparam logic [1:0] AS_REG   = 2'b00, AS_IMM   = 2'b01, AS_SHAMT = 2'b10;
  localparam logic [1:0] EMD_LW1  = 2'b00, EMD_LW2  = 2'b10, EMD_LW3 = 2'b01;
  localparam logic [1:0] LI_NONE  = 2'b00, LI_IMM   = 2'b01, LI_MOVE = 2'b10;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW1) || (op == OP_LW2) || (op == OP_LW3);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op >= OP_BEQ) && (op <= OP_BNE);
  endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational datapath-select decoder driven by FSM state and latched opcode.
module uc_decode
  import uc_pkg::*;
#(
  parameter int unsigned ALUOPW = 4
) (
  input  state_t            cur,
  input  logic [5:0]        op,
  output logic [ALUOPW-1:0] alu_op,
  output logic [1:0]        regdst,
  output logic [1:0]        memtoreg,
  output logic [1:0]        alusrc,
  output logic [1:0]        emd,
  output logic [1:0]        loadi
);

  logic [3:0] alu;

  always_comb begin
    alu      = ALU_LDST;
    regdst   = '0;
    memtoreg = '0;
    alusrc   = '0;
    emd      = '0;
    loadi    = '0;
    unique case (cur)
      S_EXEC: begin
        unique case (op)
          OP_RTYPE: begin alu = ALU_RTYPE; alusrc = AS_REG;   end
          OP_SHIFT: begin alu = ALU_RTYPE; alusrc = AS_SHAMT; end
          OP_ANDI:  begin alu = ALU_ANDI;  alusrc = AS_IMM;   end
          OP_ORI:   begin alu = ALU_ORI;   alusrc = AS_IMM;   end
          OP_ADDI:  begin alu = ALU_ADDI;  alusrc = AS_IMM;   end
          OP_SUBI:  begin alu = ALU_SUBI;  alusrc = AS_IMM;   end
          OP_LW1, OP_LW2, OP_LW3, OP_SW: begin alu = ALU_LDST; alusrc = AS_IMM; end
          OP_BEQ:   alu = ALU_BEQ;
          OP_BLT:   alu = ALU_BLT;
          OP_BGT:   alu = ALU_BGT;
          OP_BNE:   alu = ALU_BNE;
          default:  ;
        endcase
      end
      S_MEM: begin
        alusrc = AS_IMM;
        if (op == OP_LW2)      emd = EMD_LW2;
        else if (op == OP_LW3) emd = EMD_LW3;
        else                   emd = EMD_LW1;
      end
      S_WB: begin
        unique case (op)
          OP_RTYPE, OP_SHIFT: begin regdst = RD_RD; memtoreg = M2R_ALU; end
          OP_ANDI, OP_ORI, OP_ADDI, OP_SUBI: begin regdst = RD_RT; memtoreg = M2R_ALU; end
          OP_LI:   begin loadi = LI_IMM; regdst = RD_RT; end
          OP_MOVE: begin loadi = LI_MOVE; memtoreg = M2R_ALU; end
          OP_JAL:  begin regdst = RD_RA; memtoreg = M2R_PC; end
          default: ;
        endcase
      end
      S_IN_WAIT: loadi = LI_IMM;
      default: ;
    endcase
  end

  assign alu_op = ALUOPW'(alu);

endmodule

// File: rtl/unidade_controle_mc.sv
// Multi-cycle MIPS-style control unit: FSM, latched opcode, MEM wait counter,
// sticky illegal-opcode trap and IN/OUT handshakes.
module unidade_controle_mc
  import uc_pkg::*;
#(
  parameter int unsigned OPW     = 6,
  parameter int unsigned ALUOPW  = 4,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned STW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              in_valid,
  input  logic              out_ack,
  output logic              pc_write,
  output logic              pc_load,
  output logic              ir_write,
  output logic [ALUOPW-1:0] AluOP,
  output logic [1:0]        regdst,
  output logic [1:0]        memtoreg,
  output logic [1:0]        alusrc,
  output logic [1:0]        emd,
  output logic [1:0]        loadi,
  output logic              jump,
  output logic              jumpreg,
  output logic              branch,
  output logic              memread,
  output logic              memwrite,
  output logic              regwrite,
  output logic              in,
  output logic              out,
  output logic              halted,
  output logic              illegal,
  output logic              waiting_in,
  output logic [STW-1:0]    state
);

  state_t         cur, nxt;
  logic [OPW-1:0] op_reg;
  logic [3:0]     mem_cnt;
  logic [5:0]     op_raw, op_lat;
  logic           legal, mem_done;

  assign op_raw   = 6'(opcode);
  assign op_lat   = 6'(op_reg);
  assign legal    = (opcode <= OPW'(OP_NOP));
  assign mem_done = (mem_cnt == 4'(MEM_LAT - 1));
  assign state    = STW'(cur);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_FETCH;
      op_reg  <= '0;
      mem_cnt <= '0;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        op_reg <= opcode;
        if (!legal) illegal <= 1'b1;
      end
      if (cur == S_MEM) mem_cnt <= mem_done ? '0 : mem_cnt + 4'd1;
    end
  end

  // DECODE acts on the raw opcode; later states only see the latched copy.
  always_comb begin
    nxt        = cur;
    pc_write   = 1'b0;
    pc_load    = 1'b0;
    ir_write   = 1'b0;
    jump       = 1'b0;
    jumpreg    = 1'b0;
    branch     = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    in         = 1'b0;
    out        = 1'b0;
    halted     = 1'b0;
    waiting_in = 1'b0;
    unique case (cur)
      S_FETCH: begin
        memread  = 1'b1;
        ir_write = 1'b1;
        pc_write = 1'b1;
        nxt      = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) nxt = S_HALT;
        else begin
          unique case (op_raw)
            OP_LI, OP_MOVE, OP_JAL: nxt = S_WB;
            OP_JR:   begin pc_load = 1'b1; jumpreg = 1'b1; nxt = S_FETCH; end
            OP_J:    begin pc_load = 1'b1; jump = 1'b1;    nxt = S_FETCH; end
            OP_NOP:  nxt = S_FETCH;
            OP_IN:   nxt = S_IN_WAIT;
            OP_OUT:  nxt = S_OUT;
            OP_HALT: nxt = S_HALT;
            default: nxt = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        if (is_branch(op_lat)) begin
          branch  = 1'b1;
          pc_load = 1'b1;
          nxt     = S_FETCH;
        end else if (is_load(op_lat) || op_lat == OP_SW) nxt = S_MEM;
        else nxt = S_WB;
      end
      S_MEM: begin
        memread  = is_load(op_lat);
        memwrite = (op_lat == OP_SW);
        if (mem_done) nxt = (op_lat == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        regwrite = 1'b1;
        if (op_lat == OP_JAL) begin
          jump    = 1'b1;
          pc_load = 1'b1;
        end
        nxt = S_FETCH;
      end
      S_IN_WAIT: begin
        waiting_in = 1'b1;
        in         = 1'b1;
        if (in_valid) begin
          regwrite = 1'b1;
          nxt      = S_FETCH;
        end
      end
      S_OUT: begin
        out = 1'b1;
        if (out_ack) nxt = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: nxt = S_FETCH;
    endcase
  end

  uc_decode #(.ALUOPW(ALUOPW)) u_decode (
    .cur      (cur),
    .op       (op_lat),
    .alu_op   (AluOP),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .alusrc   (alusrc),
    .emd      (emd),
    .loadi    (loadi)
  );

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Self-checking bench: per-instruction phase sequences derived from the
// instruction latency rules, with every output checked each cycle.
module tb_unidade_controle_mc;

  localparam int LAT = 3;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcl, irw;
    logic [3:0] alu;
    logic [1:0] rd, mr, as, emd, li;
    logic       j, jr, br, mrd, mwr, rw, inn, outt, hlt, ill, wi;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ack;
  logic [5:0] opcode;
  logic       pc_write, pc_load, ir_write;
  logic [3:0] AluOP;
  logic [1:0] regdst, memtoreg, alusrc, emd, loadi;
  logic       jump, jumpreg, branch, memread, memwrite, regwrite, in, out;
  logic       halted, illegal, waiting_in;
  logic [3:0] state;
  vec_t       got;

  int checks = 0;
  int errors = 0;
  bit ill_m  = 1'b0;

  always #5 clk = ~clk;

  unidade_controle_mc #(.OPW(6), .ALUOPW(4), .MEM_LAT(LAT), .STW(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .in_valid(in_valid), .out_ack(out_ack),
    .pc_write(pc_write), .pc_load(pc_load), .ir_write(ir_write), .AluOP(AluOP),
    .regdst(regdst), .memtoreg(memtoreg), .alusrc(alusrc), .emd(emd), .loadi(loadi),
    .jump(jump), .jumpreg(jumpreg), .branch(branch), .memread(memread),
    .memwrite(memwrite), .regwrite(regwrite), .in(in), .out(out), .halted(halted),
    .illegal(illegal), .waiting_in(waiting_in), .state(state)
  );

  assign got = {state, pc_write, pc_load, ir_write, AluOP, regdst, memtoreg, alusrc,
                emd, loadi, jump, jumpreg, branch, memread, memwrite, regwrite, in, out,
                halted, illegal, waiting_in};

  // Expected outputs for one cycle: ph is the phase (0=FETCH..7=HALT).
  function automatic vec_t exp_vec(input int ph, input int op, input bit iv, input bit ill);
    vec_t v;
    v     = '0;
    v.st  = 4'(ph);
    v.ill = ill;
    case (ph)
      0: begin v.mrd = 1; v.irw = 1; v.pcw = 1; end
      1: begin
        if (op == 2)  begin v.pcl = 1; v.jr = 1; end
        if (op == 19) begin v.pcl = 1; v.j = 1; end
      end
      2: begin
        if (op <= 1)                 v.alu = 4'd1;
        else if (op >= 3 && op <= 6) v.alu = 4'(op + 3);
        else if (op >= 8 && op <= 11) v.alu = 4'd0;
        else                          v.alu = 4'(op - 10);
        if (op == 0 || op >= 12) v.as = 2'd0;
        else if (op == 1)        v.as = 2'd2;
        else                     v.as = 2'd1;
        if (op >= 12) begin v.br = 1; v.pcl = 1; end
      end
      3: begin
        v.as  = 2'd1;
        v.mrd = (op < 11);
        v.mwr = (op == 11);
        v.emd = (op == 9) ? 2'd2 : (op == 10) ? 2'd1 : 2'd0;
      end
      4: begin
        v.rw = 1;
        if (op <= 1)       begin v.rd = 2'd1; v.mr = 2'd1; end
        else if (op <= 6)  v.mr = 2'd1;
        else if (op == 7)  v.li = 2'd1;
        else if (op == 18) begin v.li = 2'd2; v.mr = 2'd1; end
        else if (op == 20) begin v.rd = 2'd2; v.mr = 2'd2; v.j = 1; v.pcl = 1; end
      end
      5: begin v.wi = 1; v.inn = 1; v.li = 2'd1; v.rw = iv; end
      6: v.outt = 1;
      7: v.hlt = 1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic step(input vec_t e, input logic [5:0] opc, input bit iv, input bit ack,
                      input bit r, input string tag);
    @(negedge clk);
    opcode   = opc;
    in_valid = iv;
    out_ack  = ack;
    rst      = r;
    #1;
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, e);
    end
  endtask

  task automatic run_op(input int op, input int dly);
    int q[$];
    bit legal;
    legal = (op <= 22);
    q = {0, 1};
    if (!legal || op == 21) repeat (10) q.push_back(7);
    else if (op inside {0, 1, 3, 4, 5, 6}) q = {q, 2, 4};
    else if (op inside {8, 9, 10}) begin
      q.push_back(2);
      repeat (LAT) q.push_back(3);
      q.push_back(4);
    end else if (op == 11) begin
      q.push_back(2);
      repeat (LAT) q.push_back(3);
    end else if (op >= 12 && op <= 15) q.push_back(2);
    else if (op inside {7, 18, 20}) q.push_back(4);
    else if (op == 16) repeat (dly + 1) q.push_back(5);
    else if (op == 17) repeat (dly + 1) q.push_back(6);
    for (int k = 0; k < q.size(); k++) begin
      bit last, iv, ack, r;
      logic [5:0] opc;
      last = (k == q.size() - 1);
      iv   = (q[k] == 5) ? last : 1'($urandom);
      ack  = (q[k] == 6) ? last : 1'($urandom);
      r    = (q[k] == 7) && last;
      // After DECODE the opcode bus is scrambled: later phases must use the latched copy.
      opc  = (k < 2) ? 6'(op) : 6'($urandom);
      step(exp_vec(q[k], op, iv, ill_m), opc, iv, ack, r,
           $sformatf("op%0d ph%0d k%0d", op, q[k], k));
      if (q[k] == 1 && !legal) ill_m = 1'b1;
      if (r) ill_m = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ack = 1'b0; opcode = '0;
    @(posedge clk);
    step(exp_vec(0, 0, 0, 0), 6'd0, 0, 0, 1, "reset");

    run_op(0, 0);    // ADD
    run_op(9, 0);    // LW2 with three MEM cycles
    run_op(16, 5);   // IN held off five cycles
    run_op(17, 2);   // OUT acked on third cycle
    run_op(63, 0);   // illegal opcode trap, then reset
    run_op(21, 0);   // HALT, then reset

    // SW aborted by reset in its first MEM cycle
    step(exp_vec(0, 11, 0, 0), 6'd11, 0, 0, 0, "swrst F");
    step(exp_vec(1, 11, 0, 0), 6'd11, 0, 0, 0, "swrst D");
    step(exp_vec(2, 11, 0, 0), 6'd11, 0, 0, 0, "swrst E");
    step(exp_vec(3, 11, 0, 0), 6'd11, 0, 0, 1, "swrst M");
    step(exp_vec(0, 22, 0, 0), 6'd22, 0, 0, 0, "swrst F after");
    step(exp_vec(1, 22, 0, 0), 6'd22, 0, 0, 0, "swrst D nop");

    for (int n = 0; n < 80; n++)
      run_op(int'($urandom_range(0, 27)), int'($urandom_range(0, 4)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
